// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the iterative square-root core.
// Holds the FSM state encoding, format helpers and the canonical quiet-NaN builder.
package fp_sqrt_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CALC, ROUND, DONE} state_t;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int width(input int exp_w, input int mant_w);
      return 1 + exp_w + mant_w;
   endfunction

   // Sign, all-ones exponent and mantissa MSB set; caller truncates to the format width.
   function automatic logic [63:0] qnan_const(input int exp_w, input int mant_w);
      logic [63:0] ones;
      ones = '1;
      return (ones >> (64 - (exp_w + 2))) << (mant_w - 1);
   endfunction

endpackage

// File: rtl/fp_sqrt_lzc.sv
// Leading-zero count and left-normalisation of a denormal significand.
// Purely combinational; an all-zero input reports WIDTH and normalises to zero.
module fp_sqrt_lzc #(
   parameter int WIDTH = 11
) (
   input  logic [WIDTH-1:0]             din,
   output logic [$clog2(WIDTH+1)-1:0]   lz,
   output logic [WIDTH-1:0]             norm
);

   localparam int LZ_W = $clog2(WIDTH + 1);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      lz = LZ_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) lz = LZ_W'(WIDTH - 1 - i);
      end
   end

   assign norm = din << lz;

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754-style square root, one root bit per cycle, valid/ready on both sides.
// Define FP_SQRT_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_sqrt_iter
   import fp_sqrt_pkg::*;
#(
   parameter int EXP_W  = 5,
   parameter int MANT_W = 10
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [EXP_W+MANT_W:0]     IN_DATA,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   output logic [EXP_W+MANT_W:0]     OUT_DATA,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic                      IS_NAN,
   output logic                      IS_PINF,
   output logic                      IS_NINF
);

   localparam int W     = width(EXP_W, MANT_W);
   localparam int BIAS  = bias(EXP_W);
   localparam int SW    = MANT_W + 1;
   localparam int RW    = MANT_W + 2;
   localparam int REM_W = MANT_W + 4;
   localparam int LZ_W  = $clog2(SW + 1);
   localparam int EW    = EXP_W + LZ_W + 2;
   localparam int CNT_W = $clog2(RW);
   localparam logic [W-1:0]     QNAN = W'(qnan_const(EXP_W, MANT_W));
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RW - 1);

   function automatic logic [W-1:0] round_result(input logic [EXP_W-1:0]  ex,
                                                 input logic [MANT_W-1:0] mant,
                                                 input logic              inc);
      logic [MANT_W:0] sum;
      sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
      return {1'b0, ex + {{(EXP_W-1){1'b0}}, sum[MANT_W]}, sum[MANT_W-1:0]};
   endfunction

   state_t state, state_nxt;
   logic [CNT_W-1:0] iter_cnt;

   logic [W-1:0]       op_p0;
   logic [2*RW-1:0]    rad_p1;
   logic [REM_W-1:0]   rem_p1;
   logic [RW-1:0]      root_p1;
   logic [EXP_W-1:0]   exp_p1;

   logic               op_sign;
   logic [EXP_W-1:0]   op_exp;
   logic [MANT_W-1:0]  op_mant;
   logic               exp_max, exp_zero, mant_zero, special;
   logic [W-1:0]       spec_data;
   logic               spec_nan, spec_pinf;
   logic [LZ_W-1:0]    lz;
   logic [SW-1:0]      den_sig, sig_p0;
   logic [RW-1:0]      rad_p0;
   logic signed [EW-1:0] e_p0, half_p0;
   logic [EXP_W-1:0]   res_exp_p0;
   logic [REM_W+1:0]   rem_sh, trial, diff;
   logic               take, rnd_inc;

   assign op_sign = op_p0[W-1];
   assign op_exp  = op_p0[W-2:MANT_W];
   assign op_mant = op_p0[MANT_W-1:0];

   assign exp_max   = &op_exp;
   assign exp_zero  = ~|op_exp;
   assign mant_zero = ~|op_mant;
   assign special   = (exp_zero & mant_zero) | exp_max | op_sign;

   // NaN check precedes the sign check so negative NaNs keep their payload.
   always_comb begin
      spec_data = op_p0;
      spec_nan  = 1'b0;
      spec_pinf = 1'b0;
      if (exp_max && !mant_zero) begin
         spec_data = op_p0 | (W'(1) << (MANT_W - 1));
         spec_nan  = 1'b1;
      end else if (exp_zero && mant_zero) begin
         spec_data = op_p0;
      end else if (op_sign) begin
         spec_data = QNAN;
         spec_nan  = 1'b1;
      end else begin
         spec_pinf = 1'b1;
      end
   end

   fp_sqrt_lzc #(.WIDTH(SW)) u_lzc (
      .din  ({1'b0, op_mant}),
      .lz   (lz),
      .norm (den_sig)
   );

   // An odd exponent is folded into the radicand so the halved exponent is exact.
   always_comb begin
      if (exp_zero) e_p0 = EW'(1 - BIAS) - EW'(lz);
      else          e_p0 = EW'(op_exp) - EW'(BIAS);
      half_p0    = e_p0 >>> 1;
      res_exp_p0 = EXP_W'(half_p0 + EW'(BIAS));
      sig_p0     = exp_zero ? den_sig : {1'b1, op_mant};
      rad_p0     = e_p0[0] ? {sig_p0, 1'b0} : {1'b0, sig_p0};
   end

   always_comb begin
      rem_sh = {rem_p1, rad_p1[2*RW-1 -: 2]};
      trial  = (REM_W+2)'({root_p1, 2'b01});
      take   = (rem_sh >= trial);
      diff   = rem_sh - trial;
   end

`ifdef FP_SQRT_RNE_EN
   assign rnd_inc = root_p1[0] & ((|rem_p1) | root_p1[1]);
`else
   assign rnd_inc = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (IN_VALID) state_nxt = LOAD;
         LOAD:    state_nxt = special ? DONE : CALC;
         CALC:    if (iter_cnt == LAST) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (OUT_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         iter_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == LOAD)      iter_cnt <= '0;
         else if (state == CALC) iter_cnt <= iter_cnt + 1'b1;
      end
   end

   // p0: operand capture; p1: radicand, partial remainder and root
   always_ff @(posedge CLK) begin
      if (state == IDLE && IN_VALID) op_p0 <= IN_DATA;
      if (state == LOAD) begin
         rad_p1  <= {rad_p0, {RW{1'b0}}};
         rem_p1  <= '0;
         root_p1 <= '0;
         exp_p1  <= res_exp_p0;
      end else if (state == CALC) begin
         rad_p1  <= rad_p1 << 2;
         rem_p1  <= take ? diff[REM_W-1:0] : rem_sh[REM_W-1:0];
         root_p1 <= {root_p1[RW-2:0], take};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_DATA <= '0;
         IS_NAN   <= 1'b0;
         IS_PINF  <= 1'b0;
      end else if (state == LOAD && special) begin
         OUT_DATA <= spec_data;
         IS_NAN   <= spec_nan;
         IS_PINF  <= spec_pinf;
      end else if (state == ROUND) begin
         OUT_DATA <= round_result(exp_p1, root_p1[MANT_W:1], rnd_inc);
         IS_NAN   <= 1'b0;
         IS_PINF  <= 1'b0;
      end
   end

   assign IN_READY  = (state == IDLE);
   assign OUT_VALID = (state == DONE);
   assign IS_NINF   = 1'b0;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Directed bench for fp_sqrt_iter (binary16 defaults): vector table plus
// backpressure and mid-operation reset sequences.
module tb_fp_sqrt_iter;

   logic        CLK;
   logic        RST;
   logic [15:0] IN_DATA;
   logic        IN_VALID;
   logic        IN_READY;
   logic [15:0] OUT_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic        IS_NAN;
   logic        IS_PINF;
   logic        IS_NINF;

   int checks   = 0;
   int failures = 0;

   localparam int NV     = 19;
   localparam int LAT_N  = 14;
   localparam int LAT_S  = 1;
   localparam int BUDGET = 40;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
      logic        nan;
      logic        pinf;
      int          lat;
   } vec_t;

   vec_t vecs [NV];

   fp_sqrt_iter dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .IS_NAN    (IS_NAN),
      .IS_PINF   (IS_PINF),
      .IS_NINF   (IS_NINF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic run_op(input logic [15:0] din, output logic [15:0] d, output logic n,
                         output logic p, output logic ni, output int lat);
      @(negedge CLK);
      check($sformatf("in_ready_%h", din), {31'd0, IN_READY}, 32'd1);
      IN_DATA  = din;
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      lat = 0;
      while (!OUT_VALID && lat < BUDGET) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      d  = OUT_DATA;
      n  = IS_NAN;
      p  = IS_PINF;
      ni = IS_NINF;
      @(negedge CLK);
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      check($sformatf("valid_drop_%h", din), {31'd0, OUT_VALID}, 32'd0);
   endtask

   initial begin
      logic [15:0] d;
      logic        n, p, ni;
      int          lat;

      vecs[0]  = '{16'h4400, 16'h4000, 1'b0, 1'b0, LAT_N};
      vecs[1]  = '{16'h4000, 16'h3DA8, 1'b0, 1'b0, LAT_N};
`ifdef FP_SQRT_RNE_EN
      vecs[2]  = '{16'h4200, 16'h3EEE, 1'b0, 1'b0, LAT_N};
      vecs[3]  = '{16'h03FF, 16'h1FFF, 1'b0, 1'b0, LAT_N};
`else
      vecs[2]  = '{16'h4200, 16'h3EED, 1'b0, 1'b0, LAT_N};
      vecs[3]  = '{16'h03FF, 16'h1FFE, 1'b0, 1'b0, LAT_N};
`endif
      vecs[4]  = '{16'h0001, 16'h0C00, 1'b0, 1'b0, LAT_N};
      vecs[5]  = '{16'h0200, 16'h1DA8, 1'b0, 1'b0, LAT_N};
      vecs[6]  = '{16'h4C00, 16'h4400, 1'b0, 1'b0, LAT_N};
      vecs[7]  = '{16'h3C00, 16'h3C00, 1'b0, 1'b0, LAT_N};
      vecs[8]  = '{16'h3400, 16'h3800, 1'b0, 1'b0, LAT_N};
      vecs[9]  = '{16'h3800, 16'h39A8, 1'b0, 1'b0, LAT_N};
      vecs[10] = '{16'h7BFF, 16'h5BFF, 1'b0, 1'b0, LAT_N};
      vecs[11] = '{16'h8000, 16'h8000, 1'b0, 1'b0, LAT_S};
      vecs[12] = '{16'h0000, 16'h0000, 1'b0, 1'b0, LAT_S};
      vecs[13] = '{16'hBC00, 16'hFE00, 1'b1, 1'b0, LAT_S};
      vecs[14] = '{16'h7C01, 16'h7E01, 1'b1, 1'b0, LAT_S};
      vecs[15] = '{16'h7C00, 16'h7C00, 1'b0, 1'b1, LAT_S};
      vecs[16] = '{16'hFC00, 16'hFE00, 1'b1, 1'b0, LAT_S};
      vecs[17] = '{16'hFD55, 16'hFF55, 1'b1, 1'b0, LAT_S};
      vecs[18] = '{16'h7D55, 16'h7F55, 1'b1, 1'b0, LAT_S};

      RST       = 1'b1;
      IN_VALID  = 1'b0;
      IN_DATA   = 16'h0000;
      OUT_READY = 1'b0;
      #3;
      check("rst_out_data", {16'd0, OUT_DATA}, 32'd0);
      check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
      check("rst_flags", {29'd0, IS_NAN, IS_PINF, IS_NINF}, 32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].din, d, n, p, ni, lat);
         check($sformatf("data_%h", vecs[i].din), {16'd0, d}, {16'd0, vecs[i].dout});
         check($sformatf("nan_%h", vecs[i].din), {31'd0, n}, {31'd0, vecs[i].nan});
         check($sformatf("pinf_%h", vecs[i].din), {31'd0, p}, {31'd0, vecs[i].pinf});
         check($sformatf("ninf_%h", vecs[i].din), {31'd0, ni}, 32'd0);
         check($sformatf("lat_%h", vecs[i].din), lat, vecs[i].lat);
      end

      // Backpressure: result held, extra requests ignored, accept one cycle after release.
      @(negedge CLK);
      IN_DATA  = 16'h4400;
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      lat = 0;
      while (!OUT_VALID && lat < BUDGET) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      check("bp_lat", lat, LAT_N);
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         IN_VALID = k[0];
         IN_DATA  = 16'h3C00;
         check("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
         check("bp_hold_data", {16'd0, OUT_DATA}, 32'h4000);
         check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
      end
      @(negedge CLK);
      IN_VALID  = 1'b1;
      IN_DATA   = 16'h4C00;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      check("bp_release_valid", {31'd0, OUT_VALID}, 32'd0);
      check("bp_release_ready", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      check("bp_accept_busy", {31'd0, IN_READY}, 32'd0);
      lat = 0;
      while (!OUT_VALID && lat < BUDGET) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      check("bp_next_lat", lat, LAT_N);
      check("bp_next_data", {16'd0, OUT_DATA}, 32'h4400);
      @(negedge CLK);
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;

      // Asynchronous reset in the middle of an iteration.
      @(negedge CLK);
      IN_DATA  = 16'h4000;
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      repeat (5) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check("mid_rst_data", {16'd0, OUT_DATA}, 32'd0);
      check("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
      check("mid_rst_ready", {31'd0, IN_READY}, 32'd1);
      check("mid_rst_flags", {29'd0, IS_NAN, IS_PINF, IS_NINF}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      run_op(16'h4400, d, n, p, ni, lat);
      check("post_rst_data", {16'd0, d}, 32'h4000);
      check("post_rst_flags", {29'd0, n, p, ni}, 32'd0);
      check("post_rst_lat", lat, LAT_N);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
